// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode, funct and ALU codes plus the control-word type for the decode stage
//
// Contents:
//   OP_*        instruction[31:26] encodings that the decoder recognises
//   FN_*        instruction[5:0] encodings for R-type (OP = 000000)
//   ALU_*       4-bit ALU operation codes driven on ALU_Op
//   ctrl_word_t packed control word; the all-zero value is the NOP word
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_XNOR  = 6'b101000;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_ADDU  = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_SUBU  = 4'b0011;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_OR    = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0110;
    localparam logic [3:0] ALU_XNOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_LUI   = 4'b1010;
    // Zero result when operands differ, so the zero flag reads as "not equal".
    localparam logic [3:0] ALU_CMPNE = 4'b1011;

    typedef struct packed {
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_a;
        logic       reg_dst;
        logic       reg_write;
        logic       jump;
        logic       branch;
        logic       se_ze;
        logic [3:0] alu_op;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;

    // Control word shared by every I-type arithmetic/logic instruction.
    function automatic ctrl_word_t imm_alu_word(input logic [3:0] alu, input logic sext);
        ctrl_word_t w;
        w           = CTRL_NOP;
        w.alu_src_a = 1'b1;
        w.reg_write = 1'b1;
        w.se_ze     = sext;
        w.alu_op    = alu;
        return w;
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational OP/Func to control-word decoder
//
// Ports:
//   op    in  6   instruction[31:26]
//   func  in  6   instruction[5:0]; consulted only for R-type
//   ctrl  out 13  decoded control word (NOP for unsupported encodings)
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    output ctrl_word_t  ctrl
);

    logic       r_valid;
    logic [3:0] r_alu;

    // R-type funct lookup; an unknown or X funct falls to the default arm.
    always_comb begin
        r_valid = 1'b1;
        r_alu   = ALU_ADD;
        case (func)
            FN_ADD:  r_alu = ALU_ADD;
            FN_ADDU: r_alu = ALU_ADDU;
            FN_SUB:  r_alu = ALU_SUB;
            FN_SUBU: r_alu = ALU_SUBU;
            FN_AND:  r_alu = ALU_AND;
            FN_OR:   r_alu = ALU_OR;
            FN_XOR:  r_alu = ALU_XOR;
            FN_XNOR: r_alu = ALU_XNOR;
            FN_SLT:  r_alu = ALU_SLT;
            FN_SLTU: r_alu = ALU_SLTU;
            default: r_valid = 1'b0;
        endcase
    end

    // Only the R-type arm reads the funct results, so X on func cannot
    // reach the control word for any other opcode.
    always_comb begin
        ctrl = CTRL_NOP;
        case (op)
            OP_RTYPE: begin
                if (r_valid) begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = r_alu;
                end
            end
            OP_ADDI:  ctrl = imm_alu_word(ALU_ADD,  1'b1);
            OP_ADDIU: ctrl = imm_alu_word(ALU_ADDU, 1'b1);
            OP_SLTI:  ctrl = imm_alu_word(ALU_SLT,  1'b1);
            OP_SLTIU: ctrl = imm_alu_word(ALU_SLTU, 1'b1);
            OP_ANDI:  ctrl = imm_alu_word(ALU_AND,  1'b0);
            OP_ORI:   ctrl = imm_alu_word(ALU_OR,   1'b0);
            OP_XORI:  ctrl = imm_alu_word(ALU_XOR,  1'b0);
            OP_LUI:   ctrl = imm_alu_word(ALU_LUI,  1'b0);
            OP_LW: begin
                ctrl            = imm_alu_word(ALU_ADD, 1'b1);
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.se_ze     = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.se_ze  = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                ctrl.branch = 1'b1;
                ctrl.se_ze  = 1'b1;
                ctrl.alu_op = ALU_CMPNE;
            end
            OP_J:    ctrl.jump = 1'b1;
            default: ctrl = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// rtl/mips_controller.sv - decode-stage controller with registered control word
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears to NOP word)
//   en                load enable; low holds the current word (stall)
//   OP, Func          instruction[31:26], instruction[5:0]
//   MemtoReg .. Se_ze control strobes into ID/EX
//   ALU_Op            4-bit ALU operation code
module mips_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [5:0] OP,
    input  logic [5:0] Func,
    output logic       MemtoReg,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       Jump,
    output logic       Branch,
    output logic       Se_ze,
    output logic [3:0] ALU_Op
);

    ctrl_word_t ctrl_d;
    ctrl_word_t ctrl_q;

    mips_ctrl_decode u_decode (
        .op   (OP),
        .func (Func),
        .ctrl (ctrl_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_NOP;
        end else if (en) begin
            ctrl_q <= ctrl_d;
        end
    end

    assign MemtoReg = ctrl_q.mem_to_reg;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign ALUSrcA  = ctrl_q.alu_src_a;
    assign RegDst   = ctrl_q.reg_dst;
    assign RegWrite = ctrl_q.reg_write;
    assign Jump     = ctrl_q.jump;
    assign Branch   = ctrl_q.branch;
    assign Se_ze    = ctrl_q.se_ze;
    assign ALU_Op   = ctrl_q.alu_op;

endmodule

// File: tb/tb_mips_controller.sv
// tb/tb_mips_controller.sv - scoreboard bench for mips_controller against a table-driven reference
module tb_mips_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [5:0] OP;
    logic [5:0] Func;
    logic       MemtoReg, MemRead, MemWrite, ALUSrcA, RegDst, RegWrite, Jump, Branch, Se_ze;
    logic [3:0] ALU_Op;

    mips_controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .OP       (OP),
        .Func     (Func),
        .MemtoReg (MemtoReg),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ALUSrcA  (ALUSrcA),
        .RegDst   (RegDst),
        .RegWrite (RegWrite),
        .Jump     (Jump),
        .Branch   (Branch),
        .Se_ze    (Se_ze),
        .ALU_Op   (ALU_Op)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Word layout: {MemtoReg,MemRead,MemWrite,ALUSrcA,RegDst,RegWrite,Jump,Branch,Se_ze,ALU_Op}
    logic [12:0] exp_q[$];
    logic [12:0] held;
    logic [12:0] op_tab [logic [5:0]];
    logic [3:0]  fn_tab [logic [5:0]];
    logic [5:0]  op_pool[$];
    logic [5:0]  fn_pool[$];

    function automatic logic [12:0] dut_word();
        return {MemtoReg, MemRead, MemWrite, ALUSrcA, RegDst, RegWrite, Jump, Branch, Se_ze, ALU_Op};
    endfunction

    function automatic logic [12:0] mk(input bit m2r, input bit mr, input bit mw, input bit src,
                                       input bit dst, input bit rw, input bit j, input bit br,
                                       input bit se, input logic [3:0] alu);
        return {m2r, mr, mw, src, dst, rw, j, br, se, alu};
    endfunction

    function automatic logic [12:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            if (!$isunknown(fn) && fn_tab.exists(fn))
                return mk(0, 0, 0, 0, 1, 1, 0, 0, 0, fn_tab[fn]);
            return 13'd0;
        end
        if (op_tab.exists(op)) return op_tab[op];
        return 13'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
    endtask

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic e);
        @(negedge clk);
        OP   = op;
        Func = fn;
        en   = e;
        @(posedge clk);
        if (!rst_n)  held = 13'd0;
        else if (e)  held = ref_decode(op, fn);
        exp_q.push_back(held);
    endtask

    // Monitor: one registered word is visible after every rising edge.
    always begin
        logic [12:0] want;
        logic [12:0] got;
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = dut_word();
            check("ctrl_word", {19'd0, got}, {19'd0, want});
            check("no_x", {31'd0, $isunknown(got)}, 32'd0);
            check("mem_rd_wr_excl", {31'd0, MemRead & MemWrite}, 32'd0);
            check("jump_branch_excl", {31'd0, Jump & Branch}, 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        op_tab[6'b001000] = mk(0, 0, 0, 1, 0, 1, 0, 0, 1, 4'b0000);
        op_tab[6'b001001] = mk(0, 0, 0, 1, 0, 1, 0, 0, 1, 4'b0001);
        op_tab[6'b001010] = mk(0, 0, 0, 1, 0, 1, 0, 0, 1, 4'b1000);
        op_tab[6'b001011] = mk(0, 0, 0, 1, 0, 1, 0, 0, 1, 4'b1001);
        op_tab[6'b001100] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 4'b0100);
        op_tab[6'b001101] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 4'b0101);
        op_tab[6'b001110] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 4'b0110);
        op_tab[6'b001111] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 4'b1010);
        op_tab[6'b100011] = mk(1, 1, 0, 1, 0, 1, 0, 0, 1, 4'b0000);
        op_tab[6'b101011] = mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 4'b0000);
        op_tab[6'b000100] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0010);
        op_tab[6'b000101] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b1011);
        op_tab[6'b000010] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000);
        fn_tab[6'b100000] = 4'b0000;
        fn_tab[6'b100001] = 4'b0001;
        fn_tab[6'b100010] = 4'b0010;
        fn_tab[6'b100011] = 4'b0011;
        fn_tab[6'b100100] = 4'b0100;
        fn_tab[6'b100101] = 4'b0101;
        fn_tab[6'b100110] = 4'b0110;
        fn_tab[6'b101000] = 4'b0111;
        fn_tab[6'b101010] = 4'b1000;
        fn_tab[6'b101011] = 4'b1001;
        foreach (op_tab[k]) op_pool.push_back(k);
        op_pool.push_back(6'b000000);
        op_pool.push_back(6'b000000);
        foreach (fn_tab[k]) fn_pool.push_back(k);

        // Reset holds the NOP word regardless of the decode input.
        held  = 13'd0;
        rst_n = 1'b0;
        en    = 1'b1;
        OP    = 6'b001000;
        Func  = 6'b000000;
        #1;
        check("reset_word", {19'd0, dut_word()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(6'b001000, 6'b000000, 1'b1);

        // R-type sweep.
        foreach (fn_tab[k]) step(6'b000000, k, 1'b1);

        // Memory, branch and jump.
        step(6'b100011, 6'b000000, 1'b1);
        step(6'b101011, 6'b000000, 1'b1);
        step(6'b000100, 6'b000000, 1'b1);
        step(6'b000101, 6'b000000, 1'b1);
        step(6'b000010, 6'b000000, 1'b1);

        // X on Func is ignored outside R-type; unsupported encodings give NOP.
        step(6'b001101, 6'bxxxxxx, 1'b1);
        step(6'b111111, 6'b100000, 1'b1);
        step(6'b000000, 6'b000111, 1'b1);

        // Stall then release.
        step(6'b000000, 6'b100000, 1'b1);
        step(6'b101011, 6'b000000, 1'b0);
        step(6'b101011, 6'b000000, 1'b0);
        step(6'b101011, 6'b000000, 1'b1);

        // Asynchronous reset mid-operation, then the first enabled edge loads.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_word", {19'd0, dut_word()}, 32'd0);
        held = 13'd0;
        step(6'b100011, 6'b000000, 1'b1);
        #3;
        rst_n = 1'b1;
        step(6'b100011, 6'b000000, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            logic       e;
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            else op = op_pool[$urandom_range(0, op_pool.size() - 1)];
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
            else fn = fn_pool[$urandom_range(0, fn_pool.size() - 1)];
            e = ($urandom_range(0, 3) != 0);
            step(op, fn, e);
        end

        @(posedge clk);
        #4;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
